// File: rtl/usb_tx_encoder.sv
//-----------------------------------------------------------------------------
// usb_tx_encoder
//
// Transmit line encoder for a USB full-speed link. Packet bytes arrive over a
// valid/ready handshake into a one-byte holding register. The encoder sends
// SYNC, then each byte LSB-first, inserts a stuffed 0 after every run of six
// transmitted 1s, NRZI-encodes the bit stream onto the D+/D- pair and closes
// the packet with EOP (SE0, SE0, J).
//
// Parameters
//   CLKS_PER_BIT   clk cycles per line bit time (2 or more)
//
// Ports
//   clk            system clock
//   n_rst          asynchronous active-low reset (line returns to J at once)
//   tx_start       one-cycle packet request, honored only while idle
//   tx_data        packet byte
//   tx_data_valid  tx_data holds a byte
//   tx_last        tx_data is the final byte of the packet
//   tx_data_ready  holding register empty; a byte moves on valid && ready
//   tx_busy        packet in progress, SYNC through EOP
//   tx_error       one-cycle pulse when the holding register underruns
//   dplus_out      D+ drive
//   dminus_out     D- drive
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'h80;
  localparam logic [2:0]    STUFF_RUN = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t        state_q, state_d;

  // Bit timer: the line and the state only move when it wraps.
  logic [TW-1:0] timer_q, timer_d;

  // Shifter: in SYNC/DATA, shift_q[0] is the bit currently on the line and
  // bit_cnt_q its index. In STUFF they describe the data bit that resumes
  // after the stuffed 0. In EOP_SE0 bit_cnt_q counts the SE0 bit times.
  logic [7:0]    shift_q, shift_d;
  logic          shift_last_q, shift_last_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;

  // Run length of consecutive transmitted 1s, for bit stuffing.
  logic [2:0]    ones_q, ones_d;

  // A stuff bit owed after the final data bit; EOP follows it.
  logic          eop_pend_q, eop_pend_d;

  // One-byte holding register in front of the shifter.
  logic [7:0]    hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_full_q, hold_full_d;

  // Registered outputs.
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          bit_wrap;
  logic          byte_end;
  logic          stuff_due;
  logic          underrun;
  logic          emit_data;
  logic          emit_bit;
  logic          emit_stuff;

  assign bit_wrap  = (timer_q == TIMER_MAX);
  assign stuff_due = (ones_q == STUFF_RUN);
  assign byte_end  = bit_wrap && (bit_cnt_q == 3'd7) &&
                     ((state_q == S_SYNC) || (state_q == S_DATA));
  // The byte just finished was not the last one, and nothing is waiting.
  assign underrun  = byte_end && !shift_last_q && !hold_full_q;

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  //---------------------------------------------------------------------------
  // Next-state logic
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tx_start) state_d = S_SYNC;
      end
      S_SYNC, S_DATA: begin
        if (bit_wrap) begin
          if (bit_cnt_q == 3'd7) begin
            if (underrun)          state_d = S_EOP_SE0;
            else if (stuff_due)    state_d = S_STUFF;
            else if (shift_last_q) state_d = S_EOP_SE0;
            else                   state_d = S_DATA;
          end else if (stuff_due) begin
            state_d = S_STUFF;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_STUFF: begin
        if (bit_wrap) state_d = eop_pend_q ? S_EOP_SE0 : S_DATA;
      end
      S_EOP_SE0: begin
        if (bit_wrap && (bit_cnt_q == 3'd1)) state_d = S_EOP_J;
      end
      S_EOP_J: begin
        if (bit_wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  //---------------------------------------------------------------------------
  // Datapath and output next-state logic
  //---------------------------------------------------------------------------
  always_comb begin
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    eop_pend_d   = eop_pend_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    dp_d         = dp_q;
    dm_d         = dm_q;
    busy_d       = busy_q;
    err_d        = 1'b0;
    emit_data    = 1'b0;
    emit_bit     = 1'b0;
    emit_stuff   = 1'b0;

    timer_d = ((state_q == S_IDLE) || bit_wrap) ? '0 : timer_q + 1'b1;

    // Accept into the holding register in any state, including idle, so the
    // first byte can be preloaded ahead of tx_start.
    if (tx_data_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_last_d = tx_last;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          busy_d       = 1'b1;
          shift_d      = SYNC_BYTE;
          shift_last_d = 1'b0;
          bit_cnt_d    = 3'd0;
          eop_pend_d   = 1'b0;
          ones_d       = '0;
          emit_data    = 1'b1;
          emit_bit     = SYNC_BYTE[0];
        end
      end

      S_SYNC, S_DATA: begin
        if (bit_wrap) begin
          if (bit_cnt_q == 3'd7) begin
            if (underrun) begin
              // Drop the packet and close the line straight away.
              err_d     = 1'b1;
              dp_d      = 1'b0;
              dm_d      = 1'b0;
              bit_cnt_d = 3'd0;
            end else if (shift_last_q) begin
              if (stuff_due) begin
                emit_stuff = 1'b1;
                eop_pend_d = 1'b1;
              end else begin
                dp_d      = 1'b0;
                dm_d      = 1'b0;
                bit_cnt_d = 3'd0;
              end
            end else begin
              shift_d      = hold_q;
              shift_last_d = hold_last_q;
              hold_full_d  = 1'b0;
              bit_cnt_d    = 3'd0;
              eop_pend_d   = 1'b0;
              if (stuff_due) begin
                emit_stuff = 1'b1;
              end else begin
                emit_data = 1'b1;
                emit_bit  = hold_q[0];
              end
            end
          end else begin
            // Advance before a possible stuff so STUFF resumes on shift_q[0].
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (stuff_due) begin
              emit_stuff = 1'b1;
            end else begin
              emit_data = 1'b1;
              emit_bit  = shift_q[1];
            end
          end
        end
      end

      S_STUFF: begin
        if (bit_wrap) begin
          if (eop_pend_q) begin
            dp_d      = 1'b0;
            dm_d      = 1'b0;
            bit_cnt_d = 3'd0;
          end else begin
            emit_data = 1'b1;
            emit_bit  = shift_q[0];
          end
        end
      end

      S_EOP_SE0: begin
        if (bit_wrap) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd1) begin
            dp_d = 1'b1;
            dm_d = 1'b0;
          end
        end
      end

      S_EOP_J: begin
        if (bit_wrap) busy_d = 1'b0;
      end

      default: ;
    endcase

    // NRZI: a 0 (data or stuffed) toggles J/K, a 1 holds the line.
    if (emit_stuff || (emit_data && !emit_bit)) begin
      dp_d   = ~dp_q;
      dm_d   = ~dm_q;
      ones_d = '0;
    end else if (emit_data) begin
      ones_d = ones_q + 1'b1;
    end
  end

  //---------------------------------------------------------------------------
  // Datapath registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      timer_q      <= '0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      eop_pend_q   <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      dp_q         <= 1'b1;
      dm_q         <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      eop_pend_q   <= eop_pend_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      dp_q         <= dp_d;
      dm_q         <= dm_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign tx_data_ready = ~hold_full_q;
  assign tx_busy       = busy_q;
  assign tx_error      = err_q;
  assign dplus_out     = dp_q;
  assign dminus_out    = dm_q;

endmodule
